// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, stage indices into the valid vector and parameter defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        SQUASH   = 2'd3
    } pctrl_state_t;

    // Bit positions in stage_valid, {wb,mem,ex,id}
    localparam int STG_ID     = 0;
    localparam int STG_EX     = 1;
    localparam int STG_MEM    = 2;
    localparam int STG_WB     = 3;
    localparam int NUM_STAGES = 4;

    localparam int REG_AW_DEF   = 5;
    localparam int ZERO_REG_DEF = 31;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core datapath and the hazard controller.
// master = datapath side (supplies hazard inputs, consumes controls),
// slave  = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              br_taken;
    logic              mem_req;
    logic              mem_ack;

    logic              pc_en;
    logic              en_ifid;
    logic              en_idex;
    logic              en_exmem;
    logic              en_memwb;
    logic              flush_ifid;
    logic              flush_idex;
    logic [3:0]        stage_valid;
    logic [1:0]        state_o;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_is_load, br_taken, mem_req, mem_ack,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
               stage_valid, state_o
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_is_load, br_taken, mem_req, mem_ack,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
               stage_valid, state_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare: the load in EX writes a register the
// instruction in ID is about to read. The zero register never forms a hazard.
module hazard_detect #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              valid_ex,
    input  logic              valid_id,
    output logic              load_use
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 & (ex_rd == id_rs2);

    assign load_use = ex_is_load & valid_ex & valid_id
                    & (ex_rd != ZERO_IDX)
                    & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: per-buffer load enables,
// bubble injection for load-use and taken branches, full freeze while data
// memory is busy, and a valid bit per stage.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/squash counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_hazard_ctrl_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     squash_cnt
`endif
);

    pctrl_state_t state_reg, state_next;

    logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic flush_ifid, flush_idex;
    logic load_use;
    logic mem_stall;

    logic [NUM_STAGES-1:0] valid_vec;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_d;

    hazard_detect #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_is_load  (bus.ex_is_load),
        .valid_ex    (valid_vec[STG_EX]),
        .valid_id    (valid_vec[STG_ID]),
        .load_use    (load_use)
    );

    // Memory stays busy from the first un-acked request until the ack cycle
    assign mem_stall = ~bus.mem_ack & (bus.mem_req | (state_reg == MEM_WAIT));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Next state and Mealy controls; priority mem wait > branch > load-use
    always_comb begin
        state_next = RUN;
        pc_en      = 1'b1;
        en_ifid    = 1'b1;
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (reset) begin
            if (mem_stall) begin
                pc_en      = 1'b0;
                en_ifid    = 1'b0;
                en_idex    = 1'b0;
                en_exmem   = 1'b0;
                en_memwb   = 1'b0;
                state_next = MEM_WAIT;
            end else if (bus.br_taken && valid_vec[STG_EX]) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                state_next = SQUASH;
            end else if (load_use && (state_reg != SQUASH) && (state_reg != LD_STALL)) begin
                // ID holds a bubble in SQUASH; in LD_STALL the stall already happened
                pc_en      = 1'b0;
                en_ifid    = 1'b0;
                flush_idex = 1'b1;
                state_next = LD_STALL;
            end
        end
    end

    assign stage_en = {en_memwb, en_exmem, en_idex, en_ifid};
    assign stage_d  = {valid_vec[STG_MEM],
                       valid_vec[STG_EX],
                       valid_vec[STG_ID] & ~flush_idex,
                       ~flush_ifid};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_valid
            logic valid_reg;
            // Valid bit advances only when its buffer loads
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)            valid_reg <= 1'b0;
                else if (stage_en[gi]) valid_reg <= stage_d[gi];
            end
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] squash_cnt_reg;

    // Saturating counts of PC-stalled cycles and taken-branch flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg  <= '0;
            squash_cnt_reg <= '0;
        end else begin
            if (!pc_en && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_ifid && (squash_cnt_reg != '1))
                squash_cnt_reg <= squash_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign squash_cnt = squash_cnt_reg;
`endif

    assign bus.pc_en       = pc_en;
    assign bus.en_ifid     = en_ifid;
    assign bus.en_idex     = en_idex;
    assign bus.en_exmem    = en_exmem;
    assign bus.en_memwb    = en_memwb;
    assign bus.flush_ifid  = flush_ifid;
    assign bus.flush_idex  = flush_idex;
    assign bus.stage_valid = valid_vec;
    assign bus.state_o     = state_reg;

endmodule
